// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer and its return stack.
package pc_sequencer_pkg;

  localparam int          DEF_ADDR_W    = 16;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam int          DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FETCH,
    HOLD,
    REDIR
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int W     = DEF_ADDR_W,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_up;
  logic [PW:0]   count;
  logic          full;

  assign ptr_up = ptr + PW'(1);
  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign top    = mem[ptr];

  // ptr always names the newest entry; the count saturates so wrapping drops the oldest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_up;
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_up] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer driving an external PC; return stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              imem_ack,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              call,
  input  logic              ret,
  output logic              pc_wr,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic              fetch_done,
  output logic              ras_err
);

  seq_state_t        state, state_n;
  logic              pc_wr_n, imem_req_n, fetch_done_n, ras_err_n;
  logic [ADDR_W-1:0] pc_next_n, pc_inc;
  logic              ras_push, ras_pop, ras_empty, ret_req, call_req;
  logic [ADDR_W-1:0] ras_top;

  assign pc_inc = pc_cur + ADDR_W'(1);

`ifdef PC_SEQ_RAS_EN
  assign ret_req  = ret;
  assign call_req = call;

  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .top   (ras_top),
    .empty (ras_empty)
  );
`else
  logic unused_ras;
  assign ret_req    = 1'b0;
  assign call_req   = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = call ^ ret ^ ras_push ^ ras_pop ^ (RAS_DEPTH == 0);
`endif

  // Requests are only taken when no PC load is in flight, so pc_cur is never stale
  always_comb begin
    state_n      = state;
    pc_wr_n      = 1'b0;
    pc_next_n    = pc_next;
    imem_req_n   = 1'b0;
    fetch_done_n = 1'b0;
    ras_err_n    = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_wr_n   = 1'b1;
          pc_next_n = RESET_VEC;
          state_n   = INIT;
        end
      end
      INIT: state_n = FETCH;
      FETCH, HOLD: begin
        if (!pc_wr) begin
          if (redirect) begin
            pc_wr_n   = 1'b1;
            pc_next_n = redirect_pc;
            ras_push  = call_req;
            state_n   = REDIR;
          end else if (ret_req && !ras_empty) begin
            pc_wr_n   = 1'b1;
            pc_next_n = ras_top;
            ras_pop   = 1'b1;
            state_n   = REDIR;
          end else begin
            ras_err_n = ret_req;
            if (state == FETCH) begin
              if (imem_req && imem_ack) begin
                fetch_done_n = 1'b1;
                if (stall) begin
                  state_n = HOLD;
                end else begin
                  pc_wr_n   = 1'b1;
                  pc_next_n = pc_inc;
                end
              end
            end else if (!stall) begin
              pc_wr_n   = 1'b1;
              pc_next_n = pc_inc;
              state_n   = FETCH;
            end
          end
        end
      end
      REDIR:   state_n = FETCH;
      default: state_n = IDLE;
    endcase
    if (halt) begin
      state_n      = IDLE;
      pc_wr_n      = 1'b0;
      pc_next_n    = pc_next;
      fetch_done_n = 1'b0;
      ras_err_n    = 1'b0;
      ras_push     = 1'b0;
      ras_pop      = 1'b0;
    end
    imem_req_n = (state_n == FETCH) && !pc_wr_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc_wr      <= 1'b0;
      pc_next    <= '0;
      imem_req   <= 1'b0;
      fetch_done <= 1'b0;
      ras_err    <= 1'b0;
    end else begin
      state      <= state_n;
      pc_wr      <= pc_wr_n;
      pc_next    <= pc_next_n;
      imem_req   <= imem_req_n;
      fetch_done <= fetch_done_n;
      ras_err    <= ras_err_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC-load and fetch scoreboard.
module tb_pc_sequencer;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, halt = 1'b0, imem_ack = 1'b0, stall = 1'b0;
  logic        redirect = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] pc_cur, pc_reg, pc_next;
  logic        pc_wr, imem_req, fetch_done, ras_err;

  int          compared = 0, mismatched = 0;
  logic [15:0] exp_wr_q[$];
  logic [15:0] exp_fd_q[$];
  logic        prev_wr = 1'b0;
  logic        err_window = 1'b0;

  pc_sequencer #(.ADDR_W(16), .RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .pc_cur      (pc_cur),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .call        (call),
    .ret         (ret),
    .pc_wr       (pc_wr),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .fetch_done  (fetch_done),
    .ras_err     (ras_err)
  );

  always #5 clk = ~clk;

  // The program counter the sequencer controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pc_reg <= '0;
    else if (pc_wr) pc_reg <= pc_next;
  end
  assign pc_cur = pc_reg;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_wr = 1'b0;
    end else begin
      checkOutput("pc_wr_back_to_back", 32'(prev_wr & pc_wr), 32'd0);
      if (exp_wr_q.size() == 0) checkOutput("pc_wr_unexpected", 32'(pc_wr), 32'd0);
      else if (pc_wr)           checkOutput("pc_next", 32'(pc_next), 32'(exp_wr_q.pop_front()));
      if (exp_fd_q.size() == 0) checkOutput("fetch_done_unexpected", 32'(fetch_done), 32'd0);
      else if (fetch_done)      checkOutput("fetch_done_addr", 32'(pc_cur), 32'(exp_fd_q.pop_front()));
      if (!err_window) checkOutput("ras_err_quiet", 32'(ras_err), 32'd0);
      prev_wr = pc_wr;
    end
  end

  task automatic waitReq(input string tag);
    int n = 0;
    while (!imem_req && n < 40) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic doFetch(input logic [15:0] addr, input logic hold);
    logic [15:0] nxt;
    nxt = addr + 16'd1;
    waitReq("fetch_req");
    checkOutput("fetch_addr", 32'(pc_cur), 32'(addr));
    exp_fd_q.push_back(addr);
    if (!hold) exp_wr_q.push_back(nxt);
    stall    = hold;
    imem_ack = 1'b1;
    applyStimulus(1);
    imem_ack = 1'b0;
  endtask

  // Redirect is held into the REDIR cycle with a bogus target, which must be ignored
  task automatic doRedirect(input logic [15:0] target, input logic with_call, input logic with_ack);
    waitReq("redir_req");
    exp_wr_q.push_back(target);
    redirect    = 1'b1;
    redirect_pc = target;
    call        = with_call;
    imem_ack    = with_ack;
    applyStimulus(1);
    imem_ack    = 1'b0;
    call        = 1'b0;
    redirect_pc = ~target;
    checkOutput("redir_req_low", 32'(imem_req), 32'd0);
    applyStimulus(1);
    redirect = 1'b0;
    checkOutput("redir_one_cycle", 32'(imem_req), 32'd1);
    checkOutput("redir_target", 32'(pc_cur), 32'(target));
  endtask

  initial begin
    applyStimulus(1);
    checkOutput("rst_pc_wr", 32'(pc_wr), 32'd0);
    checkOutput("rst_pc_next", 32'(pc_next), 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_fetch_done", 32'(fetch_done), 32'd0);
    checkOutput("rst_ras_err", 32'(ras_err), 32'd0);

    rst = 1'b1;
    imem_ack = 1'b1;
    applyStimulus(1);
    imem_ack = 1'b0;
    checkOutput("idle_ack_no_req", 32'(imem_req), 32'd0);
    checkOutput("idle_ack_no_done", 32'(fetch_done), 32'd0);
    applyStimulus(2);
    checkOutput("idle_waits", 32'(imem_req), 32'd0);

    exp_wr_q.push_back(16'h0000);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("init_no_req", 32'(imem_req), 32'd0);
    for (int a = 0; a < 5; a++) doFetch(16'(a), 1'b0);

    doFetch(16'h0005, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_no_req", 32'(imem_req), 32'd0);
      if (i < 2) applyStimulus(1);
    end
    exp_wr_q.push_back(16'h0006);
    stall = 1'b0;
    applyStimulus(1);
    for (int a = 6; a < 16; a++) doFetch(16'(a), 1'b0);

    doRedirect(16'h0200, 1'b0, 1'b1);
    doFetch(16'h0200, 1'b0);
    doRedirect(16'h0020, 1'b0, 1'b0);

`ifdef PC_SEQ_RAS_EN
    doRedirect(16'h0300, 1'b1, 1'b0);
    doFetch(16'h0300, 1'b0);
    waitReq("ret_req");
    exp_wr_q.push_back(16'h0021);
    ret = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    checkOutput("ret_no_err", 32'(ras_err), 32'd0);
    applyStimulus(1);
    checkOutput("ret_target", 32'(pc_cur), 32'h0021);
    waitReq("ret2_req");
    exp_fd_q.push_back(16'h0021);
    exp_wr_q.push_back(16'h0022);
    err_window = 1'b1;
    ret = 1'b1;
    imem_ack = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    imem_ack = 1'b0;
    checkOutput("ras_underflow", 32'(ras_err), 32'd1);
    applyStimulus(1);
    checkOutput("ras_err_one_cycle", 32'(ras_err), 32'd0);
    err_window = 1'b0;
`else
    doRedirect(16'h0300, 1'b1, 1'b0);
    waitReq("ret_req");
    exp_fd_q.push_back(16'h0300);
    exp_wr_q.push_back(16'h0301);
    ret = 1'b1;
    imem_ack = 1'b1;
    applyStimulus(1);
    ret = 1'b0;
    imem_ack = 1'b0;
    checkOutput("ret_ignored_err", 32'(ras_err), 32'd0);
`endif

    doRedirect(16'hFFFF, 1'b0, 1'b0);
    doFetch(16'hFFFF, 1'b0);
    doFetch(16'h0000, 1'b0);

    waitReq("halt_req");
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0123;
    imem_ack = 1'b1;
    applyStimulus(1);
    redirect = 1'b0;
    imem_ack = 1'b0;
    checkOutput("halt_no_req", 32'(imem_req), 32'd0);
    checkOutput("halt_no_wr", 32'(pc_wr), 32'd0);
    applyStimulus(1);
    halt = 1'b0;
    applyStimulus(2);
    checkOutput("halt_stays_idle", 32'(imem_req), 32'd0);
    exp_wr_q.push_back(16'h0000);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    doFetch(16'h0000, 1'b0);

    waitReq("rst_mid_req");
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_req_low", 32'(imem_req), 32'd0);
    checkOutput("rst_mid_pc_wr", 32'(pc_wr), 32'd0);
    checkOutput("rst_mid_pc_next", 32'(pc_next), 32'd0);
    applyStimulus(1);
    rst = 1'b1;
    imem_ack = 1'b1;
    applyStimulus(1);
    imem_ack = 1'b0;
    checkOutput("rst_ack_ignored", 32'(fetch_done), 32'd0);
    applyStimulus(2);
    checkOutput("rst_idle_until_start", 32'(imem_req), 32'd0);
    exp_wr_q.push_back(16'h0000);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    doFetch(16'h0000, 1'b0);
    doFetch(16'h0001, 1'b0);
    applyStimulus(3);

    checkOutput("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    checkOutput("fd_queue_drained", 32'(exp_fd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
